// File: rtl/alu_core_pkg.sv
// Shared opcode/state encodings and latency constants for the alu_core block.
package alu_core_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_MUL = 3'b100,
        OP_RST = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } alu_state_t;

    // Edges from accept to the edge at which done is first sampled high.
    localparam int LOGIC_LATENCY = 2;

    function automatic int mul_latency(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/alu_core_mul.sv
// Iterative shift-add multiplier: one partial-product bit of b per cycle, LSB first.
module alu_core_mul #(
    parameter int ALU_IN_OP_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic [ALU_IN_OP_WIDTH-1:0]   a_i,
    input  logic [ALU_IN_OP_WIDTH-1:0]   b_i,
    output logic                         busy_o,
    output logic                         last_o,
    output logic [2*ALU_IN_OP_WIDTH-1:0] product_o
);
    import alu_core_pkg::*;

    localparam int W  = ALU_IN_OP_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic          busy_q;
    logic [CW-1:0] cnt_q;
    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] mcand_q;
    logic [W-1:0]  mplier_q;
    logic [2*W-1:0] acc_d;

    // product_o already includes the current partial product, so on the last
    // cycle it is the complete product and can be registered by the caller.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    assign busy_o    = busy_q;
    assign last_o    = busy_q && (cnt_q == CW'(W - 1));
    assign product_o = acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {{W{1'b0}}, a_i};
            mplier_q <= b_i;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (last_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_core.sv
// Multi-cycle ALU: FSM, operand capture, add/logic datapath and result register.
module alu_core
    import alu_core_pkg::*;
#(
    parameter int ALU_IN_OP_WIDTH      = 8,
    parameter int ALU_OUT_RESULT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            valid,
    output logic                            ready,
    input  logic [2:0]                      op,
    input  logic [ALU_IN_OP_WIDTH-1:0]      a,
    input  logic [ALU_IN_OP_WIDTH-1:0]      b,
    output logic                            done,
    output logic [ALU_OUT_RESULT_WIDTH-1:0] result,
    output alu_state_t                      dbg_state
);
    localparam int W  = ALU_IN_OP_WIDTH;
    localparam int RW = ALU_OUT_RESULT_WIDTH;

    generate
        if (RW < 2 * W) begin : g_width_check
            $error("alu_core: ALU_OUT_RESULT_WIDTH must be >= 2*ALU_IN_OP_WIDTH");
        end
    endgenerate

    alu_state_t    state_q, state_d;
    logic [2:0]    op_q;
    logic [W-1:0]  a_q, b_q;
    logic [RW-1:0] result_q, result_d;
    logic [RW-1:0] logic_res;
    logic [W:0]    sum;
    logic          accept;
    logic          mul_start, mul_busy, mul_last;
    logic [2*W-1:0] mul_product;

    // Handshake: a request transfers on any posedge where valid && ready; ready
    // is held low during rst so a simultaneous request is never taken.
    assign ready     = !rst && (state_q == S_IDLE || state_q == S_DONE);
    assign done      = !rst && (state_q == S_DONE);
    assign accept    = valid && ready;
    assign mul_start = accept && (op == OP_MUL);
    assign result    = result_q;
    assign dbg_state = state_q;
    assign sum       = {1'b0, a_q} + {1'b0, b_q};

    alu_core_mul #(.ALU_IN_OP_WIDTH(W)) u_mul (
        .clk      (clk),
        .rst      (rst),
        .start_i  (mul_start),
        .a_i      (a),
        .b_i      (b),
        .busy_o   (mul_busy),
        .last_o   (mul_last),
        .product_o(mul_product)
    );

    always_comb begin
        logic_res = '0;
        case (op_q)
            OP_ADD:  logic_res = RW'(sum);
            OP_AND:  logic_res = RW'(a_q & b_q);
            OP_XOR:  logic_res = RW'(a_q ^ b_q);
            default: logic_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    case (op)
                        OP_ADD, OP_AND, OP_XOR: state_d = S_EXEC;
                        OP_MUL:                 state_d = S_MUL;
                        OP_RST:                 result_d = '0;
                        default:                state_d = S_IDLE;
                    endcase
                end
            end
            S_EXEC: begin
                state_d  = S_DONE;
                result_d = logic_res;
            end
            S_MUL: begin
                if (mul_busy && mul_last) begin
                    state_d  = S_DONE;
                    result_d = RW'(mul_product);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            if (accept) begin
                op_q <= op;
                a_q  <= a;
                b_q  <= b;
            end
        end
    end

endmodule
